// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller (master) and the ARM datapath (slave).
interface multicycle_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore main FSM with registered outputs, instruction/ALU
// decode, and conditional-execution logic owning the NZCV flag register.
module multicycle_controller #(
    parameter bit EXT_DP = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE,
        S_MEMWB, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam ctrl_t FETCH_CTRL = '{pc_write: 1'b1, ir_write: 1'b1, mem_write: 1'b0,
                                     reg_write: 1'b0, adr_src: 1'b0, alu_src_a: 1'b1,
                                     alu_src_b: 2'b10, result_src: 2'b10, alu_control: 3'b000};
    localparam ctrl_t RESET_CTRL = '{pc_write: 1'b0, ir_write: 1'b0, mem_write: 1'b0,
                                     reg_write: 1'b0, adr_src: 1'b0, alu_src_a: 1'b1,
                                     alu_src_b: 2'b10, result_src: 2'b10, alu_control: 3'b000};

    // Instruction fields (Instr carries bits 31:12 of the instruction word)
    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign i_bit     = bus.Instr[13];
    assign cmd       = bus.Instr[12:9];
    assign s_bit     = bus.Instr[8];
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^bus.Instr[7:4];

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d, ctrl_out;
    logic [3:0] flags_q;
    logic       cond_ex_q, cond_ex_d;
    logic       cond_ex;
    logic [2:0] alu_op;
    logic       dp_ok, is_cmp, dp_wb;
    logic [1:0] flag_w;
    logic       executing;

    // NOTE: every output of a combinational block is given a default first, so no path
    // through the case statements leaves a signal unassigned and infers a latch.
    always_comb begin
        alu_op = 3'b000;
        dp_ok  = 1'b0;
        is_cmp = 1'b0;
        case (cmd)
            4'b0100: begin alu_op = 3'b000; dp_ok = 1'b1; end
            4'b0010: begin alu_op = 3'b001; dp_ok = 1'b1; end
            4'b0000: begin alu_op = 3'b010; dp_ok = 1'b1; end
            4'b1100: begin alu_op = 3'b011; dp_ok = 1'b1; end
            4'b0001: if (EXT_DP) begin alu_op = 3'b100; dp_ok = 1'b1; end
            4'b1010: if (EXT_DP) begin alu_op = 3'b001; dp_ok = 1'b1; is_cmp = 1'b1; end
            default: ;
        endcase
        flag_w[1] = dp_ok & (s_bit | is_cmp);
        flag_w[0] = flag_w[1] & ((alu_op == 3'b000) | (alu_op == 3'b001));
        dp_wb     = dp_ok & ~is_cmp;
    end

    // Condition evaluated against the stored flags {N,Z,C,V}
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:               state_d = s_bit ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:              state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI: state_d = is_cmp ? S_FETCH : S_ALUWB;
            default:                state_d = S_FETCH;
        endcase
    end

    function automatic ctrl_t state_ctrl(input state_t s, input logic ok,
                                         input logic rd_pc, input logic wb_ok,
                                         input logic [2:0] op_sel);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    c = FETCH_CTRL;
            S_DECODE:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            S_MEMADR:   c.alu_src_b = 2'b01;
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = ok; end
            S_MEMWB:    begin
                c.result_src = 2'b01;
                c.pc_write   = ok & rd_pc;
                c.reg_write  = ok & ~rd_pc;
            end
            S_EXECUTER: c.alu_control = op_sel;
            S_EXECUTEI: begin c.alu_src_b = 2'b01; c.alu_control = op_sel; end
            S_ALUWB:    begin
                c.pc_write  = ok & wb_ok & rd_pc;
                c.reg_write = ok & wb_ok & ~rd_pc;
            end
            S_BRANCH:   begin c.alu_src_b = 2'b01; c.result_src = 2'b10; c.pc_write = ok; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    // Outputs are registered, so they are computed for the state being entered; leaving
    // DECODE, the condition about to be latched is the one that applies.
    assign cond_ex_d = (state_q == S_DECODE) ? cond_ex : cond_ex_q;
    assign ctrl_d    = state_ctrl(state_d, cond_ex_d, rd == 4'hF, dp_wb, alu_op);
    assign executing = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);

    // NOTE: all state is updated with non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= FETCH_CTRL;
            cond_ex_q <= 1'b0;
            flags_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            cond_ex_q <= cond_ex_d;
            if (executing && cond_ex_q) begin
                if (flag_w[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
                if (flag_w[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    // Reset overrides the registered outputs within the same cycle it is asserted.
    assign ctrl_out = reset ? RESET_CTRL : ctrl_q;

    assign bus.PCWrite    = ctrl_out.pc_write;
    assign bus.IRWrite    = ctrl_out.ir_write;
    assign bus.MemWrite   = ctrl_out.mem_write;
    assign bus.RegWrite   = ctrl_out.reg_write;
    assign bus.AdrSrc     = ctrl_out.adr_src;
    assign bus.ALUSrcA    = ctrl_out.alu_src_a;
    assign bus.ALUSrcB    = ctrl_out.alu_src_b;
    assign bus.ResultSrc  = ctrl_out.result_src;
    assign bus.ALUControl = ctrl_out.alu_control;

    // Decoder mux selects follow Instr only once it holds the current instruction.
    logic decode_valid;
    assign decode_valid = ~reset & (state_q != S_FETCH);
    assign bus.RegSrc   = decode_valid ? {(op == 2'b01) & ~s_bit, op == 2'b10} : 2'b00;
    assign bus.ImmSrc   = decode_valid ? op : 2'b00;

endmodule
